mrf_rx_decoder: RTL

MRF_RX_DECODER -- requirements
Module: mrf_rx_decoder

---
 rtl/mrf_pkg.sv | 14 +
 rtl/mrf_word_class.sv | 19 +
 rtl/mrf_rx_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mrf_pkg.sv
// rtl/mrf_pkg.sv - shared constants and state type for the MRF receive decoder
package mrf_pkg;

   localparam logic [7:0] K28_5     = 8'hBC;
   localparam logic [1:0] COMMA_ISK = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_CHECK  = 2'd2,
      ST_LOCKED = 2'd3
   } mrf_state_t;

endpackage

// File: rtl/mrf_word_class.sv
// rtl/mrf_word_class.sv - combinational comma/error classification of one received word
module mrf_word_class
   import mrf_pkg::*;
(
   input  logic [7:0] data_lo,
   input  logic [1:0] rx_is_k,
   input  logic [1:0] rx_disperr,
   input  logic [1:0] rx_notintable,
   output logic       is_comma,
   output logic       is_err
);

   assign is_comma = (rx_is_k == COMMA_ISK) && (data_lo == K28_5);

   // Any K flag is only legal as part of the comma word
   assign is_err = (|rx_disperr) || (|rx_notintable) ||
                   ((rx_is_k != 2'b00) && !is_comma);

endmodule

// File: rtl/mrf_rx_decoder.sv
// rtl/mrf_rx_decoder.sv - MRF frame alignment FSM, event/dbus extraction and counters
module mrf_rx_decoder
   import mrf_pkg::*;
#(
   parameter int FRAME_LEN   = 4,
   parameter int LOCK_FRAMES = 3,
   parameter int ERR_MAX     = 4
)(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        rx_reset_done,
   input  logic [15:0] rx_data,
   input  logic [1:0]  rx_is_k,
   input  logic [1:0]  rx_disperr,
   input  logic [1:0]  rx_notintable,
   input  logic        err_clr,
   output logic        locked,
   output logic [7:0]  event_code,
   output logic        event_valid,
   output logic [7:0]  dbus,
   output logic        dbus_valid,
   output logic [31:0] frame_cnt,
   output logic [15:0] err_cnt
);

   localparam int               POS_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);
   localparam logic [3:0]       ERR_N    = 4'(ERR_MAX);

   mrf_state_t       state, nxt_state;
   logic [POS_W-1:0] pos, nxt_pos;
   logic [3:0]       good_cnt, nxt_good;
   logic [3:0]       err_run, nxt_err_run;
   logic             is_comma, is_err, at_sof, to_hunt;
   logic             qualify, ev_ok, frame_inc;

   mrf_word_class u_class (
      .data_lo       (rx_data[7:0]),
      .rx_is_k       (rx_is_k),
      .rx_disperr    (rx_disperr),
      .rx_notintable (rx_notintable),
      .is_comma      (is_comma),
      .is_err        (is_err)
   );

   assign at_sof = (pos == '0);
   assign locked = (state == ST_LOCKED);

   always_comb begin
      nxt_state   = state;
      nxt_good    = good_cnt;
      nxt_err_run = err_run;
      to_hunt     = 1'b0;
      if (is_comma && state != ST_IDLE)
         nxt_pos = POS_W'(1);
      else
         nxt_pos = (pos == POS_LAST) ? '0 : pos + 1'b1;

      case (state)
         ST_IDLE: begin
            if (rx_reset_done)
               nxt_state = ST_HUNT;
         end
         ST_HUNT: begin
            if (is_comma) begin
               nxt_good  = 4'd1;
               nxt_state = (LOCK_N == 4'd1) ? ST_LOCKED : ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (is_err || (is_comma != at_sof))
               to_hunt = 1'b1;
            else if (is_comma) begin
               nxt_good = good_cnt + 4'd1;
               if (good_cnt + 4'd1 == LOCK_N)
                  nxt_state = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            // Misplacement drops lock at once; errors only after a run of ERR_MAX
            if (is_comma != at_sof)
               to_hunt = 1'b1;
            else if (is_err) begin
               if (err_run + 4'd1 == ERR_N)
                  to_hunt = 1'b1;
               else
                  nxt_err_run = err_run + 4'd1;
            end else
               nxt_err_run = 4'd0;
         end
         default: nxt_state = ST_IDLE;
      endcase

      if (to_hunt) begin
         nxt_state   = ST_HUNT;
         nxt_good    = 4'd0;
         nxt_err_run = 4'd0;
      end
      if (!rx_reset_done) begin
         nxt_state   = ST_IDLE;
         nxt_good    = 4'd0;
         nxt_err_run = 4'd0;
      end
   end

   // A word only qualifies if it also keeps us locked
   assign qualify   = (state == ST_LOCKED) && (nxt_state == ST_LOCKED) && !is_err;
   assign ev_ok     = qualify && !is_comma && (rx_data[7:0] != 8'h00);
   assign frame_inc = (state == ST_LOCKED) && is_comma && at_sof && !is_err;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= ST_IDLE;
         pos         <= '0;
         good_cnt    <= 4'd0;
         err_run     <= 4'd0;
         event_code  <= 8'h00;
         event_valid <= 1'b0;
         dbus        <= 8'h00;
         dbus_valid  <= 1'b0;
         frame_cnt   <= 32'd0;
         err_cnt     <= 16'd0;
      end else begin
         state       <= nxt_state;
         pos         <= nxt_pos;
         good_cnt    <= nxt_good;
         err_run     <= nxt_err_run;
         dbus_valid  <= qualify;
         event_valid <= ev_ok;
         if (qualify)
            dbus <= rx_data[15:8];
         if (ev_ok)
            event_code <= rx_data[7:0];
         if (frame_inc)
            frame_cnt <= frame_cnt + 32'd1;
         if (err_clr)
            err_cnt <= 16'd0;
         else if (is_err && state != ST_IDLE && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule
